// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requester queues and the register file write port.
// master is the requester/register-file side; slave is the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 64
);
  logic            req0_valid;
  logic            req0_ready;
  logic [4:0]      req0_addr;
  logic [XLEN-1:0] req0_data;
  logic            req1_valid;
  logic            req1_ready;
  logic [4:0]      req1_addr;
  logic [XLEN-1:0] req1_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            grant1;
  logic            idle;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  rf_we, rf_waddr, rf_wdata, grant1, idle
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output rf_we, rf_waddr, rf_wdata, grant1, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU pipe (requester 0) and the
// load/multiply unit (requester 1): per-requester FIFOs, fixed priority with starvation guard.
module regfile_wb_arbiter #(
  parameter int XLEN       = 64,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [3:0]  SMAX     = 4'(STARVE_MAX);

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= SMAX) ? SMAX : cnt + 4'd1;
  endfunction

  logic [4:0]      addr0_mem [DEPTH];
  logic [XLEN-1:0] data0_mem [DEPTH];
  logic [4:0]      addr1_mem [DEPTH];
  logic [XLEN-1:0] data1_mem [DEPTH];

  logic [AW-1:0] wp0, rp0, wp1, rp1;
  logic [AW:0]   occ0, occ1;
  logic [3:0]    starve_cnt;

  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1, sel1;
  logic [4:0]      win_addr;
  logic [XLEN-1:0] win_data;

  logic            vld_p1;
  logic [4:0]      waddr_p1;
  logic [XLEN-1:0] wdata_p1;
  logic            grant1_p1;

  // Stage p0: queue acceptance, storage and head arbitration
  assign full0  = (occ0 == OCC_FULL);
  assign full1  = (occ1 == OCC_FULL);
  assign empty0 = (occ0 == '0);
  assign empty1 = (occ1 == '0);

  assign bus.req0_ready = !full0 && rst;
  assign bus.req1_ready = !full1 && rst;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign push0 = bus.req0_valid && bus.req0_ready && (bus.req0_addr != 5'd0);
  assign push1 = bus.req1_valid && bus.req1_ready && (bus.req1_addr != 5'd0);

  assign sel1 = !empty1 && (empty0 || (starve_cnt == SMAX));
  assign pop1 = sel1;
  assign pop0 = !empty0 && !sel1;

  always_comb begin
    win_addr = addr0_mem[rp0];
    win_data = data0_mem[rp0];
    if (sel1) begin
      win_addr = addr1_mem[rp1];
      win_data = data1_mem[rp1];
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      addr0_mem[wp0] <= bus.req0_addr;
      data0_mem[wp0] <= bus.req0_data;
    end
    if (push1) begin
      addr1_mem[wp1] <= bus.req1_addr;
      data1_mem[wp1] <= bus.req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp0        <= '0;
      rp0        <= '0;
      occ0       <= '0;
      wp1        <= '0;
      rp1        <= '0;
      occ1       <= '0;
      starve_cnt <= 4'd0;
    end else begin
      if (push0) wp0 <= wp0 + AW'(1);
      if (pop0)  rp0 <= rp0 + AW'(1);
      occ0 <= occ0 + {{AW{1'b0}}, push0} - {{AW{1'b0}}, pop0};
      if (push1) wp1 <= wp1 + AW'(1);
      if (pop1)  rp1 <= rp1 + AW'(1);
      occ1 <= occ1 + {{AW{1'b0}}, push1} - {{AW{1'b0}}, pop1};
      // Count only grants that requester 1 lost while it was waiting.
      starve_cnt <= (!empty1 && pop0) ? sat_inc(starve_cnt) : 4'd0;
    end
  end

  // Stage p1: registered write port toward the register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      waddr_p1  <= 5'd0;
      wdata_p1  <= '0;
      grant1_p1 <= 1'b0;
    end else begin
      vld_p1 <= pop0 || pop1;
      if (pop0 || pop1) begin
        waddr_p1  <= win_addr;
        wdata_p1  <= win_data;
        grant1_p1 <= pop1;
      end
    end
  end

  assign bus.rf_we    = vld_p1;
  assign bus.rf_waddr = waddr_p1;
  assign bus.rf_wdata = wdata_p1;
  assign bus.grant1   = grant1_p1;
  assign bus.idle     = empty0 && empty1 && !vld_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a transaction-level
// model built from per-requester queues and the priority/starvation rules.
module tb_regfile_wb_arbiter;

  localparam int XLEN       = 64;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 3;

  typedef struct packed {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus();

  regfile_wb_arbiter #(
    .XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  ent_t            mq0[$];
  ent_t            mq1[$];
  int              m_starve;
  logic            m_we;
  logic            m_g1;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  bit              acc0, acc1;
  ent_t            p0, p1;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_g1     = 1'b0;
    m_addr   = 5'd0;
    m_data   = '0;
  endtask

  task automatic check_all();
    chk("req0_ready", bus.req0_ready, rst && (mq0.size() < DEPTH));
    chk("req1_ready", bus.req1_ready, rst && (mq1.size() < DEPTH));
    chk("rf_we",      bus.rf_we,      m_we);
    chk("rf_waddr",   bus.rf_waddr,   m_addr);
    chk("rf_wdata",   bus.rf_wdata,   m_data);
    chk("grant1",     bus.grant1,     m_g1);
    chk("idle",       bus.idle,       (mq0.size() == 0) && (mq1.size() == 0) && !m_we);
  endtask

  task automatic drive();
    bus.req0_addr = p0.a;
    bus.req0_data = p0.d;
    bus.req1_addr = p1.a;
    bus.req1_data = p1.d;
  endtask

  // One clock: model the edge from current inputs, then compare 1 time unit after it.
  task automatic tick();
    bit   w1, q1_busy;
    ent_t h, e0, e1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst) begin
      model_reset();
    end else begin
      acc0 = bus.req0_valid && (mq0.size() < DEPTH);
      acc1 = bus.req1_valid && (mq1.size() < DEPTH);
      e0.a = bus.req0_addr; e0.d = bus.req0_data;
      e1.a = bus.req1_addr; e1.d = bus.req1_data;
      q1_busy = (mq1.size() != 0);
      w1 = q1_busy && ((mq0.size() == 0) || (m_starve == STARVE_MAX));
      if (mq0.size() == 0 && mq1.size() == 0) begin
        m_we = 1'b0;
      end else begin
        if (w1) h = mq1.pop_front();
        else    h = mq0.pop_front();
        m_we   = 1'b1;
        m_addr = h.a;
        m_data = h.d;
        m_g1   = w1;
      end
      if (q1_busy && !w1) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else                m_starve = 0;
      if (acc0 && e0.a != 5'd0) mq0.push_back(e0);
      if (acc1 && e1.a != 5'd0) mq1.push_back(e1);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic ent_t new_ent(input bit zero_ok);
    ent_t e;
    e.a = zero_ok ? 5'($urandom_range(31, 0)) : 5'($urandom_range(31, 1));
    e.d = {$urandom, $urandom};
    return e;
  endfunction

  task automatic run(input int cycles, input int n0, input int n1, input bit zero_ok, input bit coin);
    int r0, r1;
    r0 = n0;
    r1 = n1;
    p0 = new_ent(zero_ok);
    p1 = new_ent(zero_ok);
    for (int c = 0; c < cycles; c++) begin
      bus.req0_valid = (r0 > 0) && (!coin || $urandom_range(1, 0) == 1);
      bus.req1_valid = (r1 > 0) && (!coin || $urandom_range(1, 0) == 1);
      drive();
      tick();
      if (acc0) begin r0--; p0 = new_ent(zero_ok); end
      if (acc1) begin r1--; p1 = new_ent(zero_ok); end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    bit got;
    bit found;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    p0 = '0;
    p1 = '0;
    drive();

    // Reset values appear without a clock edge.
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();

    // Release reset and present the single write at the very first edge.
    rst = 1'b1;
    p0.a = 5'd5;
    p0.d = 64'hDEAD_BEEF;
    bus.req0_valid = 1'b1;
    drive();
    tick();
    chk("first_edge_accept", acc0, 1'b1);
    bus.req0_valid = 1'b0;
    repeat (4) tick();

    // x0 write from requester 1 is consumed silently.
    p1.a = 5'd0;
    p1.d = 64'h1234;
    bus.req1_valid = 1'b1;
    drive();
    tick();
    chk("x0_accept", acc1, 1'b1);
    bus.req1_valid = 1'b0;
    repeat (3) tick();

    // Contention with both requesters streaming.
    run(24, 1000, 1000, 1'b0, 1'b0);
    run(8, 0, 0, 1'b0, 1'b0);

    // Backpressure on requester 1 while requester 0 saturates.
    run(10, 1000, 4, 1'b0, 1'b0);
    run(8, 0, 0, 1'b0, 1'b0);

    // Pointer wrap through ten sequential requester 1 writes.
    for (int i = 1; i <= 10; i++) begin
      p1.a = 5'(i);
      p1.d = XLEN'(i * 'h11);
      bus.req1_valid = 1'b1;
      drive();
      got = 1'b0;
      for (int t = 0; t < 5 && !got; t++) begin
        tick();
        got = acc1;
      end
      chk("wrap_accept", got, 1'b1);
    end
    bus.req1_valid = 1'b0;
    repeat (4) tick();

    // Randomized traffic including x0 destinations and idle gaps.
    run(200, 1000, 1000, 1'b1, 1'b1);
    run(8, 0, 0, 1'b0, 1'b0);

    // Reset mid-operation with queues loaded and a write in flight.
    found = 1'b0;
    p0 = new_ent(1'b0);
    p1 = new_ent(1'b0);
    for (int c = 0; c < 50 && !found; c++) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      drive();
      tick();
      if (acc0) p0 = new_ent(1'b0);
      if (acc1) p1 = new_ent(1'b0);
      found = m_we && ((mq0.size() + mq1.size()) >= (2 * DEPTH - 1));
    end
    chk("loaded_before_reset", found, 1'b1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    run(8, 0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
